rr_mux4to1: RTL and testbench
=============================

# rr_mux4to1

Four-channel round-robin multiplexer that merges four valid/ready input streams onto one registered output stream. Each output word carries a 2-bit source tag `sel`, so a downstream 1-to-4 demultiplexer can route it back to the matching lane. The block sits at the merge point of a channelized datapath. It is the collecting end of that point, and the distributing end is the demux.

## Interface
- `WIDTH`, default 8, data width of every channel and of the output.

- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `d0`..`d3`  in  WIDTH  channel N data
- `v0`..`v3`  in  1  channel N valid
- `rdy0`..`rdy3`  out  1  channel N accepted this cycle (combinational grant)
- `y`  out  WIDTH  output data (registered)
- `sel`  out  2  source channel index of `y` (registered)
- `y_valid`  out  1  output holds a word (registered)
- `y_ready`  in  1  downstream accepts `y` this cycle

## Operation
- Storage is a single output register (`y`, `sel`, `y_valid`) plus a 2-bit pointer `last`, which is the most recently granted channel.
- Two states:
  - EMPTY: `y_valid`=0.
  - FULL: `y_valid`=1.
- Load enable: `load = !y_valid || y_ready`.
- Arbitration runs when `load`=1. Channels are searched in order `last+1`, `last+2`, `last+3`, `last`, mod 4. The first channel with `vN`=1 wins.
- Only the winner's `rdyN` goes to 1. All `rdyN` are 0 when `load`=0 or no `vN` is set. Never more than one `rdyN` is high.
- On a grant to channel N, at the next edge: `y`<=`dN`, `sel`<=N, `y_valid`<=1, `last`<=N.
- On `load`=1 with no request:
  - `y_valid`<=0.
  - `y` and `sel` hold their old values. They are don't-care to the consumer.
  - `last` holds.
- While FULL and `y_ready`=0, `y`, `sel`, `y_valid` and `last` all hold.
- Transitions:
  - EMPTY->FULL on any grant.
  - FULL->FULL on drain+grant or stall.
  - FULL->EMPTY on drain with no request.
- Source obligation: a channel holds `vN` and `dN` stable until it sees `rdyN`=1. The block does not buffer unaccepted inputs.
- A channel may deassert `vN` without being granted. No transfer occurs for that channel.

## Timing
- Reset (`rst_n`=0, asynchronous, also mid-transfer): `y`=0, `sel`=0, `y_valid`=0, `last`=3, so channel 0 has first priority after reset. All `rdyN`=0 while `rst_n`=0. Any word held in the output register is discarded.
- Release: the first edge with `rst_n`=1 may load.
- Latency: one cycle. Channel N's word is accepted in cycle t (`rdyN`=1) and appears at `y` with `y_valid`=1 in cycle t+1.
- Throughput: one word per cycle when `y_ready` is held at 1.
- `rdyN` depends combinationally on `y_ready`, `y_valid`, `v0`..`v3` and `last`. There is no path from `dN` to any `rdyN`.
- Output transfer occurs on an edge where `y_valid`=1 and `y_ready`=1. A same-cycle refill is required, with no bubble.
- Fairness: with all four channels requesting continuously, each channel is granted exactly once in every 4 consecutive grants.
- Simultaneous drain and request: the drain completes and the new word loads on the same edge.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with `y_valid`=1 -> `y`=0, `sel`=0, `y_valid`=0 and all `rdyN`=0 immediately, without waiting for a clock edge. After release with only `v0`,`v3` high, the first grant is channel 0.
- Single channel: `v2`=1, `d2`=8'hA5, `y_ready`=1 from EMPTY -> `rdy2`=1 in cycle 0. Cycle 1 shows `y`=8'hA5, `sel`=2, `y_valid`=1.
- Full rotation: `v0`..`v3` held at 1 with `d0`..`d3` = 8'h10..8'h13 and `y_ready`=1 -> `sel` sequence 0,1,2,3,0,1… on consecutive cycles, `y` sequence 10,11,12,13,10…, with no bubbles.
- Backpressure: while FULL with `sel`=1, drop `y_ready` to 0 for 3 cycles with `v2`=1 -> `y`, `sel` and `y_valid` are stable and all `rdyN`=0. In the cycle `y_ready` returns to 1, `rdy2`=1, and the next cycle shows `sel`=2.
- Skip idle channels: only `v0` and `v3` high with `last`=0 -> grants alternate 3,0,3,0. `rdy1` and `rdy2` never assert.
- Drain to empty: `y_valid`=1, `y`=8'h5C, `y_ready`=1, no `vN` -> next cycle `y_valid`=0 and `y` still 8'h5C. A subsequent `v1` request is accepted immediately because the register is EMPTY, regardless of `y_ready`.

Source files
------------

// File: rtl/rr_mux4to1.sv
// Four-channel round-robin merge onto one registered output word with a 2-bit source tag.
// One cycle from rdyN to y; a drain and a refill can happen on the same edge.
module rr_mux4to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic             v0,
  input  logic             v1,
  input  logic             v2,
  input  logic             v3,
  output logic             rdy0,
  output logic             rdy1,
  output logic             rdy2,
  output logic             rdy3,
  output logic [WIDTH-1:0] y,
  output logic [1:0]       sel,
  output logic             y_valid,
  input  logic             y_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;

  logic             load;
  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       win;
  logic [1:0]       idx;
  logic             found;
  logic [WIDTH-1:0] win_dat;

  // Search starts one past the last winner so every requester is served within four grants.
  always_comb begin
    load  = (state_q == EMPTY) || y_ready;
    req   = {v3, v2, v1, v0};
    found = 1'b0;
    win   = last_q;
    idx   = last_q;
    for (int i = 1; i <= 4; i++) begin
      idx = last_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    gnt = 4'b0000;
    // rst_n gates the grant so no channel sees an accept while the register is held in reset.
    if (rst_n && load && found) gnt[win] = 1'b1;
  end

  always_comb begin
    case (win)
      2'd0:    win_dat = d0;
      2'd1:    win_dat = d1;
      2'd2:    win_dat = d2;
      default: win_dat = d3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (load) begin
      if (found) begin
        state_d = FULL;
        y_d     = win_dat;
        sel_d   = win;
        last_d  = win;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      y_q     <= '0;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign rdy0    = gnt[0];
  assign rdy1    = gnt[1];
  assign rdy2    = gnt[2];
  assign rdy3    = gnt[3];
  assign y       = y_q;
  assign sel     = sel_q;
  assign y_valid = (state_q == FULL);

endmodule

// File: tb/tb_rr_mux4to1.sv
// Bench for rr_mux4to1: directed vector table, reset sequence, then random traffic against a model.
module tb_rr_mux4to1;

  logic       clk;
  logic       rst_n;
  logic [7:0] d [4];
  logic [3:0] v;
  logic [3:0] rdy;
  logic [7:0] y;
  logic [1:0] sel;
  logic       y_valid;
  logic       y_ready;

  int checks;
  int failures;

  // model state
  logic       m_valid;
  logic [7:0] m_y;
  logic [1:0] m_sel;
  int         m_last;

  typedef struct {
    logic [3:0]  v;
    logic [31:0] dat;
    logic        ry;
    logic [3:0]  erdy;
    logic [7:0]  ey;
    logic [1:0]  esel;
    logic        evld;
  } vec_t;

  vec_t tbl[$];

  rr_mux4to1 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
    .v0(v[0]), .v1(v[1]), .v2(v[2]), .v3(v[3]),
    .rdy0(rdy[0]), .rdy1(rdy[1]), .rdy2(rdy[2]), .rdy3(rdy[3]),
    .y(y), .sel(sel), .y_valid(y_valid), .y_ready(y_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected winner from the round-robin rule; -1 when nobody is accepted.
  function automatic int exp_grant();
    if (!rst_n) return -1;
    if (m_valid && !y_ready) return -1;
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (m_last + k) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    int g;
    logic [3:0] erdy;
    checks = 0; failures = 0;
    rst_n = 1'b0; v = 4'b0000; y_ready = 1'b0;
    for (int k = 0; k < 4; k++) d[k] = 8'h00;

    // cycle-by-cycle vectors from a fresh reset
    tbl.push_back('{4'b1111, 32'h13121110, 1'b1, 4'b0001, 8'h10, 2'd0, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 1'b1, 4'b0010, 8'h11, 2'd1, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 1'b1, 4'b0100, 8'h12, 2'd2, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 1'b1, 4'b1000, 8'h13, 2'd3, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 1'b1, 4'b0001, 8'h10, 2'd0, 1'b1});
    tbl.push_back('{4'b1111, 32'h13121110, 1'b1, 4'b0010, 8'h11, 2'd1, 1'b1});
    tbl.push_back('{4'b0100, 32'h13121110, 1'b0, 4'b0000, 8'h11, 2'd1, 1'b1});
    tbl.push_back('{4'b0100, 32'h13121110, 1'b0, 4'b0000, 8'h11, 2'd1, 1'b1});
    tbl.push_back('{4'b0100, 32'h13121110, 1'b0, 4'b0000, 8'h11, 2'd1, 1'b1});
    tbl.push_back('{4'b0100, 32'h13121110, 1'b1, 4'b0100, 8'h12, 2'd2, 1'b1});
    tbl.push_back('{4'b1001, 32'h13121110, 1'b1, 4'b1000, 8'h13, 2'd3, 1'b1});
    tbl.push_back('{4'b1001, 32'h13121110, 1'b1, 4'b0001, 8'h10, 2'd0, 1'b1});
    tbl.push_back('{4'b1001, 32'h13121110, 1'b1, 4'b1000, 8'h13, 2'd3, 1'b1});
    tbl.push_back('{4'b1001, 32'h13121110, 1'b1, 4'b0001, 8'h10, 2'd0, 1'b1});
    tbl.push_back('{4'b0010, 32'h13125C10, 1'b1, 4'b0010, 8'h5C, 2'd1, 1'b1});
    tbl.push_back('{4'b0000, 32'h13125C10, 1'b1, 4'b0000, 8'h5C, 2'd1, 1'b0});
    tbl.push_back('{4'b0010, 32'h13121110, 1'b0, 4'b0010, 8'h11, 2'd1, 1'b1});
    tbl.push_back('{4'b0000, 32'h13121110, 1'b1, 4'b0000, 8'h11, 2'd1, 1'b0});
    tbl.push_back('{4'b0100, 32'h13A51110, 1'b1, 4'b0100, 8'hA5, 2'd2, 1'b1});

    repeat (2) @(posedge clk);
    #1;
    v = 4'b1111;
    #1;
    chk("reset_y", y, 8'h00);
    chk("reset_sel", sel, 2'd0);
    chk("reset_valid", y_valid, 1'b0);
    chk("reset_rdy", rdy, 4'b0000);
    v = 4'b0000;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      v = tbl[i].v;
      y_ready = tbl[i].ry;
      for (int k = 0; k < 4; k++) d[k] = tbl[i].dat[8*k +: 8];
      #3;
      chk($sformatf("vec%0d_rdy", i), rdy, tbl[i].erdy);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), y_valid, tbl[i].evld);
      chk($sformatf("vec%0d_y", i), y, tbl[i].ey);
      chk($sformatf("vec%0d_sel", i), sel, tbl[i].esel);
    end

    // asynchronous reset while FULL, then channel 0 first with v0 and v3 pending
    v = 4'b1001; y_ready = 1'b1;
    for (int k = 0; k < 4; k++) d[k] = 8'h10 + 8'(k);
    chk("pre_reset_valid", y_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_y", y, 8'h00);
    chk("async_sel", sel, 2'd0);
    chk("async_valid", y_valid, 1'b0);
    chk("async_rdy", rdy, 4'b0000);
    @(posedge clk);
    #1;
    chk("held_reset_valid", y_valid, 1'b0);
    rst_n = 1'b1;
    #2;
    chk("release_rdy", rdy, 4'b0001);
    @(posedge clk);
    #1;
    chk("release_sel", sel, 2'd0);
    chk("release_y", y, 8'h10);
    chk("release_valid", y_valid, 1'b1);

    // random traffic against the model
    v = 4'b0000;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    m_valid = 1'b0; m_y = 8'h00; m_sel = 2'd0; m_last = 3;
    @(posedge clk);
    #1;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < 4; c++) begin
        if (v[c]) begin
          if ($urandom_range(0, 9) == 0) v[c] = 1'b0;
        end else if ($urandom_range(0, 1) == 1) begin
          v[c] = 1'b1;
          d[c] = 8'($urandom);
        end
      end
      y_ready = ($urandom_range(0, 3) != 0);
      #3;
      g = exp_grant();
      erdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("rand_rdy", rdy, erdy);
      @(posedge clk);
      #1;
      if (!m_valid || y_ready) begin
        if (g >= 0) begin
          m_y = d[g]; m_sel = 2'(g); m_valid = 1'b1; m_last = g;
          v[g] = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
      end
      chk("rand_valid", y_valid, m_valid);
      chk("rand_y", y, m_y);
      chk("rand_sel", sel, m_sel);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
